// File: rtl/wfg_stim_ramp_if.sv
// AXI-stream sample port between the ramp generator and its consumer.
// The master drives valid/last/data and the slave drives ready.
interface wfg_stim_ramp_if #(
    parameter int unsigned AXIS_DATA_WIDTH = 32
);
    logic                       tvalid;
    logic                       tready;
    logic                       tlast;
    logic [AXIS_DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/wfg_stim_ramp.sv
// Sawtooth/triangle ramp source on an AXI-stream master port.
// Config is latched on enable, and tlast flags the final sample of each period.
module wfg_stim_ramp #(
    parameter int unsigned AXIS_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    wfg_stim_ramp_if.master            wfg_axis,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_mode_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_min_q_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_max_q_i
);
    localparam int unsigned W = AXIS_DATA_WIDTH;

    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    typedef struct packed {
        logic [W-1:0] val;
        dir_e         dir;
    } step_t;

    state_e       state_q, state_d;
    dir_e         dir_q, dir_d;
    logic         mode_q, mode_d;
    logic [W-1:0] inc_q, inc_d, min_q, min_d, max_q, max_d;
    logic [W-1:0] tdata_q, tdata_d;
    logic         tvalid_q, tvalid_d, tlast_q, tlast_d;

    logic [W-1:0] start_clamp;
    dir_e         first_dir;
    logic         first_last, next_last;
    step_t        next_s;
    logic         xfer;

    // Sample that follows v; sums/differences carry one extra bit for wrap detection.
    function automatic step_t ramp_next(input logic [W-1:0] v, input dir_e dir, input logic mode,
                                        input logic [W-1:0] inc, input logic [W-1:0] mn,
                                        input logic [W-1:0] mx);
        logic [W:0] sum;
        logic [W:0] diff;
        step_t      r;
        sum   = {1'b0, v} + {1'b0, inc};
        diff  = {1'b0, v} - {1'b0, inc};
        r.val = v;
        r.dir = dir;
        if (mn >= mx) begin
            r.val = mn;
            r.dir = DIR_UP;
        end else if (inc == '0) begin
            r.val = v;
        end else if (!mode) begin
            r.val = (sum > {1'b0, mx}) ? mn : sum[W-1:0];
        end else if (dir == DIR_UP) begin
            if (sum >= {1'b0, mx}) begin
                r.val = mx;
                r.dir = DIR_DOWN;
            end else begin
                r.val = sum[W-1:0];
            end
        end else if ($signed(diff) <= $signed({1'b0, mn})) begin
            r.val = mn;
            r.dir = DIR_UP;
        end else begin
            r.val = diff[W-1:0];
        end
        return r;
    endfunction

    function automatic logic ramp_last(input logic [W-1:0] v, input dir_e dir, input logic mode,
                                       input logic [W-1:0] inc, input logic [W-1:0] mn,
                                       input logic [W-1:0] mx);
        logic [W:0] sum;
        logic [W:0] diff;
        sum  = {1'b0, v} + {1'b0, inc};
        diff = {1'b0, v} - {1'b0, inc};
        if (mn >= mx)         return 1'b1;
        if (inc == '0)        return 1'b0;
        if (!mode)            return sum > {1'b0, mx};
        if (dir == DIR_UP)    return 1'b0;
        return $signed(diff) <= $signed({1'b0, mn});
    endfunction

    always_comb begin
        // A collapsed range pins every sample to min, whatever the start value.
        if (cfg_min_q_i >= cfg_max_q_i)     start_clamp = cfg_min_q_i;
        else if (cfg_start_q_i < cfg_min_q_i) start_clamp = cfg_min_q_i;
        else if (cfg_start_q_i > cfg_max_q_i) start_clamp = cfg_max_q_i;
        else                                  start_clamp = cfg_start_q_i;
        first_dir  = (cfg_mode_q_i && start_clamp == cfg_max_q_i) ? DIR_DOWN : DIR_UP;
        first_last = ramp_last(start_clamp, first_dir, cfg_mode_q_i, cfg_inc_q_i,
                               cfg_min_q_i, cfg_max_q_i);
        next_s     = ramp_next(tdata_q, dir_q, mode_q, inc_q, min_q, max_q);
        next_last  = ramp_last(next_s.val, next_s.dir, mode_q, inc_q, min_q, max_q);
    end

    assign xfer = tvalid_q & wfg_axis.tready;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        inc_d    = inc_q;
        min_d    = min_q;
        max_d    = max_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        case (state_q)
            ST_OFF: begin
                if (ctrl_en_q_i) begin
                    mode_d   = cfg_mode_q_i;
                    inc_d    = cfg_inc_q_i;
                    min_d    = cfg_min_q_i;
                    max_d    = cfg_max_q_i;
                    tdata_d  = start_clamp;
                    dir_d    = first_dir;
                    tlast_d  = first_last;
                    tvalid_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && ctrl_en_q_i) begin
                    tdata_d = next_s.val;
                    dir_d   = next_s.dir;
                    tlast_d = next_last;
                end else if (xfer) begin
                    tvalid_d = 1'b0;
                    state_d  = ST_OFF;
                end else if (!ctrl_en_q_i && tvalid_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    tvalid_d = 1'b0;
                    state_d  = ST_OFF;
                end
            end
            default: begin
                tvalid_d = 1'b0;
                state_d  = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            dir_q    <= DIR_UP;
            mode_q   <= 1'b0;
            inc_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            inc_q    <= inc_d;
            min_q    <= min_d;
            max_q    <= max_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign wfg_axis.tvalid = tvalid_q;
    assign wfg_axis.tlast  = tlast_q;
    assign wfg_axis.tdata  = tdata_q;
endmodule

// File: tb/tb_wfg_stim_ramp.sv
// Directed bench for wfg_stim_ramp: sawtooth, triangle, backpressure,
// drain/re-enable, start clamp, degenerate ranges and async reset.
module tb_wfg_stim_ramp;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [31:0] start, inc, mn, mx;
    int          tests;
    int          fails;

    wfg_stim_ramp_if #(.AXIS_DATA_WIDTH(32)) axis ();

    wfg_stim_ramp #(.AXIS_DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wfg_axis      (axis),
        .ctrl_en_q_i   (en),
        .cfg_mode_q_i  (mode),
        .cfg_start_q_i (start),
        .cfg_inc_q_i   (inc),
        .cfg_min_q_i   (mn),
        .cfg_max_q_i   (mx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks {tvalid, tlast, tdata} at the next falling edge.
    task automatic step(input string tag, input logic v, input logic l, input logic [31:0] d);
        @(negedge clk);
        chk(tag, {axis.tvalid, axis.tlast, axis.tdata}, {v, l, d});
    endtask

    task automatic set_cfg(input logic m, input logic [31:0] s, input logic [31:0] i,
                           input logic [31:0] lo, input logic [31:0] hi);
        mode  = m;
        start = s;
        inc   = i;
        mn    = lo;
        mx    = hi;
    endtask

    task automatic go_off(input string tag);
        en          = 1'b0;
        axis.tready = 1'b1;
        @(negedge clk);
        chk(tag, {33'b0, axis.tvalid}, 34'b0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        axis.tready = 1'b0;
        set_cfg(1'b0, 32'd0, 32'd4, 32'd0, 32'd10);
        #2;
        chk("reset", {axis.tvalid, axis.tlast, axis.tdata}, 34'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en          = 1'b1;
        axis.tready = 1'b1;

        step("saw0", 1, 0, 0);
        step("saw1", 1, 0, 4);
        step("saw2", 1, 1, 8);
        step("saw3", 1, 0, 0);
        step("saw4", 1, 0, 4);
        step("saw5", 1, 1, 8);

        axis.tready = 1'b0;
        step("bp_hold0", 1, 1, 8);
        step("bp_hold1", 1, 1, 8);
        axis.tready = 1'b1;
        step("bp_resume0", 1, 0, 0);
        step("bp_resume1", 1, 0, 4);

        en          = 1'b0;
        axis.tready = 1'b0;
        step("drain_hold", 1, 0, 4);
        en = 1'b1;
        set_cfg(1'b0, 32'd20, 32'd5, 32'd15, 32'd30);
        step("drain_reen_ignored", 1, 0, 4);
        axis.tready = 1'b1;
        @(negedge clk);
        chk("drain_off", {33'b0, axis.tvalid}, 34'b0);
        step("reen0", 1, 0, 20);
        step("reen1", 1, 0, 25);
        step("reen2", 1, 1, 30);
        step("reen3", 1, 0, 15);
        go_off("off_a");

        set_cfg(1'b1, 32'd0, 32'd4, 32'd0, 32'd10);
        en = 1'b1;
        step("tri0", 1, 0, 0);
        step("tri1", 1, 0, 4);
        step("tri2", 1, 0, 8);
        set_cfg(1'b0, 32'd0, 32'd1, 32'd0, 32'd100);
        step("tri3_turn", 1, 0, 10);
        step("tri4", 1, 0, 6);
        step("tri5", 1, 1, 2);
        step("tri6", 1, 0, 0);
        step("tri7", 1, 0, 4);
        go_off("off_b");

        set_cfg(1'b1, 32'd50, 32'd4, 32'd0, 32'd10);
        en = 1'b1;
        step("clamp0", 1, 0, 10);
        step("clamp1", 1, 0, 6);
        step("clamp2", 1, 1, 2);
        step("clamp3", 1, 0, 0);
        go_off("off_c");

        set_cfg(1'b0, 32'd3, 32'd4, 32'd7, 32'd7);
        en = 1'b1;
        step("minmax0", 1, 1, 7);
        step("minmax1", 1, 1, 7);
        step("minmax2", 1, 1, 7);
        go_off("off_d");

        set_cfg(1'b1, 32'd5, 32'd0, 32'd0, 32'd10);
        en = 1'b1;
        step("inc0_0", 1, 0, 5);
        step("inc0_1", 1, 0, 5);
        step("inc0_2", 1, 0, 5);
        go_off("off_e");

        set_cfg(1'b0, 32'd0, 32'd4, 32'd0, 32'd10);
        en = 1'b1;
        step("rst_s0", 1, 0, 0);
        step("rst_s1", 1, 0, 4);
        step("rst_s2", 1, 1, 8);
        axis.tready = 1'b0;
        step("rst_hold", 1, 1, 8);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async", {axis.tvalid, axis.tlast, axis.tdata}, 34'b0);
        @(negedge clk);
        rst_n       = 1'b1;
        axis.tready = 1'b1;
        step("restart0", 1, 0, 0);
        step("restart1", 1, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
